// File: rtl/fpnew_pkg.sv
// Shared types for the FP slice request arbiter: FSM state encoding and a
// round-robin search helper usable for up to RR_MAX_REQ requesters.
package fpnew_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[num-1:0], searching upward from ptr with wrap-around.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int unsigned           num
    );
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= num) j = j - num;
            if (i < num && !res.found && valid[j[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fpnew_id_fifo.sv
// In-order FIFO of requester IDs for operations currently inside the slice.
// Clear has the same effect as reset; pointers wrap modulo Depth.
module fpnew_id_fifo #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [IdWidth-1:0] head_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [IdWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (count == CntWidth'(Depth));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; empty/full come from count, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_id_i;
    end

endmodule

// File: rtl/fpnew_slice_req_arbiter.sv
// Shares one in-order FP format slice between NumReq requesters with
// round-robin, credit-limited admission and in-order response routing.
// Optional FPNEW_ARB_PRIO_EN adds prio_i: priority requesters are searched first.
module fpnew_slice_req_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ReqWidth       = 160,
    parameter int unsigned RspWidth       = 72
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq-1:0][ReqWidth-1:0] req_data_i,
`ifdef FPNEW_ARB_PRIO_EN
    input  logic [NumReq-1:0]               prio_i,
`endif
    output logic [NumReq-1:0]               rsp_valid_o,
    input  logic [NumReq-1:0]               rsp_ready_i,
    output logic [RspWidth-1:0]             rsp_data_o,
    output logic                            slc_valid_o,
    input  logic                            slc_ready_i,
    output logic [ReqWidth-1:0]             slc_data_o,
    input  logic                            slc_rsp_valid_i,
    output logic                            slc_rsp_ready_o,
    input  logic [RspWidth-1:0]             slc_rsp_data_i,
    input  logic                            flush_i,
    output logic                            slc_flush_o,
    output logic                            busy_o
);

    localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    arb_state_e         state;
    logic [IdWidth-1:0] rr_ptr;
    logic [IdWidth-1:0] hold_idx;

    logic [NumReq-1:0]  arb_valid;
    rr_pick_t           pick;
    logic               pick_idx_unused;
    logic               grant_valid;
    logic [IdWidth-1:0] grant_idx;
    logic [IdWidth-1:0] rr_next;
    logic               handshake;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [IdWidth-1:0] fifo_head;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        arb_valid = req_valid_i;
`ifdef FPNEW_ARB_PRIO_EN
        if ((req_valid_i & prio_i) != '0) arb_valid = req_valid_i & prio_i;
`endif
        pick = rr_pick(RR_MAX_REQ'(arb_valid), RR_IDX_W'(rr_ptr), NumReq);
    end

    assign pick_idx_unused = ^pick.idx;

    // HOLD replays the latched grant; ARB needs a free credit, even if a pop is under way.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state == HOLD) begin
            grant_valid = 1'b1;
            grant_idx   = hold_idx;
        end else if (pick.found && !fifo_full) begin
            grant_valid = 1'b1;
            grant_idx   = IdWidth'(pick.idx);
        end
    end

    assign rr_next     = (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + IdWidth'(1);
    assign slc_valid_o = grant_valid & ~flush_i;
    assign slc_data_o  = req_data_i[grant_idx];
    assign handshake   = slc_valid_o & slc_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (handshake) req_ready_o[grant_idx] = 1'b1;
    end

    // Responses return in issue order, so only the FIFO head can see the slice output.
    always_comb begin
        rsp_valid_o     = '0;
        slc_rsp_ready_o = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[fifo_head] = slc_rsp_valid_i;
            slc_rsp_ready_o        = rsp_ready_i[fifo_head];
        end
    end

    assign pop         = slc_rsp_valid_i & slc_rsp_ready_o;
    assign rsp_data_o  = slc_rsp_data_i;
    assign slc_flush_o = flush_i;
    assign busy_o      = ~fifo_empty | (state == HOLD) | slc_valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ARB;
            rr_ptr   <= '0;
            hold_idx <= '0;
        end else if (flush_i) begin
            state <= ARB;
        end else begin
            unique case (state)
                ARB: begin
                    if (grant_valid) begin
                        if (slc_ready_i) begin
                            rr_ptr <= rr_next;
                        end else begin
                            state    <= HOLD;
                            hold_idx <= grant_idx;
                        end
                    end
                end
                HOLD: begin
                    if (slc_ready_i) begin
                        state  <= ARB;
                        rr_ptr <= rr_next;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    fpnew_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdWidth)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (flush_i),
        .push_i    (handshake),
        .push_id_i (grant_idx),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

    hold_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == HOLD && !flush_i) |-> req_valid_i[hold_idx])
        else $error("held requester dropped req_valid_i");

    no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_empty && slc_rsp_valid_i))
        else $error("slice response with no operation in flight");

endmodule

// File: tb/tb_fpnew_slice_req_arbiter.sv
// Self-checking bench for fpnew_slice_req_arbiter: vector table plus hand
// sequences, responses routed against a queue of expected requester IDs.
module tb_fpnew_slice_req_arbiter;

    localparam int unsigned NumReq         = 4;
    localparam int unsigned MaxOutstanding = 4;
    localparam int unsigned ReqWidth       = 160;
    localparam int unsigned RspWidth       = 72;
    localparam int          NumVec         = 23;

    logic                            clk_i = 1'b0;
    logic                            rst_i;
    logic [NumReq-1:0]               req_valid_i;
    logic [NumReq-1:0]               req_ready_o;
    logic [NumReq-1:0][ReqWidth-1:0] req_data_i;
`ifdef FPNEW_ARB_PRIO_EN
    logic [NumReq-1:0]               prio_i;
`endif
    logic [NumReq-1:0]               rsp_valid_o;
    logic [NumReq-1:0]               rsp_ready_i;
    logic [RspWidth-1:0]             rsp_data_o;
    logic                            slc_valid_o;
    logic                            slc_ready_i;
    logic [ReqWidth-1:0]             slc_data_o;
    logic                            slc_rsp_valid_i;
    logic                            slc_rsp_ready_o;
    logic [RspWidth-1:0]             slc_rsp_data_i;
    logic                            flush_i;
    logic                            slc_flush_o;
    logic                            busy_o;

    always #5 clk_i = ~clk_i;

    fpnew_slice_req_arbiter #(
        .NumReq         (NumReq),
        .MaxOutstanding (MaxOutstanding),
        .ReqWidth       (ReqWidth),
        .RspWidth       (RspWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_data_i      (req_data_i),
`ifdef FPNEW_ARB_PRIO_EN
        .prio_i          (prio_i),
`endif
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .slc_valid_o     (slc_valid_o),
        .slc_ready_i     (slc_ready_i),
        .slc_data_o      (slc_data_o),
        .slc_rsp_valid_i (slc_rsp_valid_i),
        .slc_rsp_ready_o (slc_rsp_ready_o),
        .slc_rsp_data_i  (slc_rsp_data_i),
        .flush_i         (flush_i),
        .slc_flush_o     (slc_flush_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] prio;
        logic       sr;
        logic       rv;
        logic [3:0] rr;
        logic       fl;
        logic       e_sv;
        logic [3:0] e_rdy;
        logic [1:0] gnt;
        logic       e_srr;
        logic       e_busy;
    } vec_t;

    int unsigned         n_checks = 0;
    int unsigned         n_pass   = 0;
    logic [1:0]          sb[$];
    logic [ReqWidth-1:0] req_data [NumReq];
    vec_t                tbl [NumVec];
    vec_t                v;

    function automatic vec_t mk(
        input logic [3:0] rv_v, input logic sr, input logic rv, input logic [3:0] rr,
        input logic fl, input logic e_sv, input logic [3:0] e_rdy, input logic e_srr,
        input logic e_busy
    );
        vec_t t;
        t.v = rv_v;  t.prio = 4'b0000; t.sr = sr; t.rv = rv; t.rr = rr; t.fl = fl;
        t.e_sv = e_sv; t.e_rdy = e_rdy; t.e_srr = e_srr; t.e_busy = e_busy;
        t.gnt = 2'd0;
        for (int i = 0; i < 4; i++) if (e_rdy[i]) t.gnt = 2'(i);
        return t;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic new_req_data();
        for (int i = 0; i < NumReq; i++) begin
            req_data[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            req_data_i[i] = req_data[i];
        end
    endtask

    // Drive one cycle right after a rising edge, compare at the falling edge.
    task automatic apply(input vec_t t, input string tag);
        logic [NumReq-1:0] exp_rsp;
        req_valid_i     = t.v;
        slc_ready_i     = t.sr;
        slc_rsp_valid_i = t.rv;
        rsp_ready_i     = t.rr;
        flush_i         = t.fl;
`ifdef FPNEW_ARB_PRIO_EN
        prio_i          = t.prio;
`endif
        slc_rsp_data_i  = RspWidth'({$urandom, $urandom, $urandom});
        @(negedge clk_i);
        exp_rsp = '0;
        if (t.rv && sb.size() != 0) exp_rsp[sb[0]] = 1'b1;
        check({tag, ".slc_valid"}, 256'(slc_valid_o), 256'(t.e_sv));
        check({tag, ".req_ready"}, 256'(req_ready_o), 256'(t.e_rdy));
        check({tag, ".rsp_valid"}, 256'(rsp_valid_o), 256'(exp_rsp));
        check({tag, ".slc_rsp_ready"}, 256'(slc_rsp_ready_o), 256'(t.e_srr));
        check({tag, ".busy"}, 256'(busy_o), 256'(t.e_busy));
        check({tag, ".slc_flush"}, 256'(slc_flush_o), 256'(t.fl));
        check({tag, ".rsp_data"}, 256'(rsp_data_o), 256'(slc_rsp_data_i));
        if (t.e_sv) check({tag, ".slc_data"}, 256'(slc_data_o), 256'(req_data[t.gnt]));
        if (t.fl) begin
            sb.delete();
        end else begin
            if (t.rv && t.e_srr && sb.size() != 0) void'(sb.pop_front());
            if (t.e_rdy != 4'b0000) sb.push_back(t.gnt);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fairness with one pop per cycle: grants 0,1,2,3,0.
        tbl[0]  = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0001, 0, 1);
        tbl[1]  = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b0010, 1, 1);
        tbl[2]  = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b0100, 1, 1);
        tbl[3]  = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b1000, 1, 1);
        tbl[4]  = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b0001, 1, 1);
        tbl[5]  = mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[6]  = mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0);
        // Credit limit: four grants, blocked, pop, exactly one more grant.
        tbl[7]  = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0010, 0, 1);
        tbl[8]  = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0100, 1, 1);
        tbl[9]  = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b1000, 1, 1);
        tbl[10] = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0001, 1, 1);
        tbl[11] = mk(4'b1111, 1, 0, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[12] = mk(4'b1111, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[13] = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0010, 1, 1);
        tbl[14] = mk(4'b1111, 1, 0, 4'b1111, 0, 0, 4'b0000, 1, 1);
        // Head is requester 2: its backpressure stalls the pop.
        tbl[15] = mk(4'b0000, 1, 1, 4'b0001, 0, 0, 4'b0000, 0, 1);
        tbl[16] = mk(4'b0000, 1, 1, 4'b0001, 0, 0, 4'b0000, 0, 1);
        tbl[17] = mk(4'b0000, 1, 1, 4'b0100, 0, 0, 4'b0000, 1, 1);
        tbl[18] = mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[19] = mk(4'b0100, 1, 1, 4'b1111, 0, 1, 4'b0100, 1, 1);
        tbl[20] = mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[21] = mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        tbl[22] = mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0);

        rst_i           = 1'b1;
        req_valid_i     = '0;
        slc_ready_i     = 1'b0;
        slc_rsp_valid_i = 1'b0;
        rsp_ready_i     = '0;
        flush_i         = 1'b0;
        slc_rsp_data_i  = '0;
`ifdef FPNEW_ARB_PRIO_EN
        prio_i          = '0;
`endif
        new_req_data();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset.slc_valid", 256'(slc_valid_o), 256'(0));
        check("reset.req_ready", 256'(req_ready_o), 256'(0));
        check("reset.rsp_valid", 256'(rsp_valid_o), 256'(0));
        check("reset.slc_rsp_ready", 256'(slc_rsp_ready_o), 256'(0));
        check("reset.busy", 256'(busy_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            new_req_data();
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Hold stability: req1 stalled three cycles while req2 arrives.
        new_req_data();
        v = mk(4'b0010, 0, 0, 4'b1111, 0, 1, 4'b0000, 0, 1); v.gnt = 2'd1; apply(v, "hold0");
        v = mk(4'b0110, 0, 0, 4'b1111, 0, 1, 4'b0000, 0, 1); v.gnt = 2'd1; apply(v, "hold1");
        v = mk(4'b0110, 0, 0, 4'b1111, 0, 1, 4'b0000, 0, 1); v.gnt = 2'd1; apply(v, "hold2");
        apply(mk(4'b0110, 1, 0, 4'b1111, 0, 1, 4'b0010, 0, 1), "hold3");
        apply(mk(4'b0110, 1, 0, 4'b1111, 0, 1, 4'b0100, 1, 1), "hold4");

        // Flush with three in flight and the FSM in HOLD; rr_ptr must survive.
        apply(mk(4'b0100, 1, 0, 4'b1111, 0, 1, 4'b0100, 1, 1), "flush0");
        v = mk(4'b0001, 0, 0, 4'b1111, 0, 1, 4'b0000, 1, 1); v.gnt = 2'd0; apply(v, "flush1");
        apply(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0000, 1, 1), "flush2");
        apply(mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0), "flush3");
        apply(mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b1000, 0, 1), "flush4");
        apply(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1), "flush5");
        apply(mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0), "flush6");

`ifdef FPNEW_ARB_PRIO_EN
        // Requester 3 has priority and wins until it drops valid.
        v = mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b1000, 0, 1); v.prio = 4'b1000; apply(v, "prio0");
        v = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b1000, 1, 1); v.prio = 4'b1000; apply(v, "prio1");
        v = mk(4'b1111, 1, 1, 4'b1111, 0, 1, 4'b1000, 1, 1); v.prio = 4'b1000; apply(v, "prio2");
        v = mk(4'b0111, 1, 1, 4'b1111, 0, 1, 4'b0001, 1, 1); v.prio = 4'b1000; apply(v, "prio3");
        apply(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1), "prio4");
        apply(mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0), "prio5");
`endif

        // Reset mid-operation discards in-flight IDs and rewinds rr_ptr.
        apply(mk(4'b0100, 1, 0, 4'b1111, 0, 1, 4'b0100, 0, 1), "rst0");
        apply(mk(4'b0010, 1, 0, 4'b1111, 0, 1, 4'b0010, 1, 1), "rst1");
        rst_i       = 1'b1;
        req_valid_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        apply(mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0), "rst2");
        apply(mk(4'b1111, 1, 0, 4'b1111, 0, 1, 4'b0001, 0, 1), "rst3");
        apply(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1), "rst4");
        apply(mk(4'b0000, 1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0), "rst5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
